// File: rtl/kbd_cmd_seq.sv
// kbd_cmd_seq: PS/2 keyboard command sequencer.
// Issues the reset (0xFF) and LED (0xED + mask) command sequences and handles
// ACK/resend/BAT responses with per-wait timeouts and bounded retries.
// Scancodes received while idle are forwarded to scode_out.
// Optional build macro KBD_CMD_SEQ_AUTO_INIT_EN: start the init sequence on
// the first cycle after reset deasserts.
`timescale 1ns/1ps
module kbd_cmd_seq #(
    parameter logic [31:0] TMO_CYC   = 32'd25_000_000,
    parameter logic [1:0]  RETRY_MAX = 2'd3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       init_req,
    input  logic       led_req,
    input  logic [2:0] led_val,
    output logic [7:0] tx_data,
    output logic       tx_en,
    input  logic       tx_done,
    input  logic [7:0] rx_scode,
    input  logic       rx_en,
    input  logic       rx_err,
    output logic [7:0] scode_out,
    output logic       scode_out_en,
    output logic       busy,
    output logic       init_done,
    output logic       err,
    output logic [1:0] err_code
);

    typedef enum logic [2:0] {
        IDLE,
        TX,
        WAIT_TXD,
        WAIT_ACK,
        WAIT_BAT,
        ERR
    } state_t;

    localparam logic [7:0] CMD_RESET = 8'hFF;
    localparam logic [7:0] CMD_LED   = 8'hED;
    localparam logic [7:0] RSP_ACK   = 8'hFA;
    localparam logic [7:0] RSP_RSND  = 8'hFE;
    localparam logic [7:0] RSP_BATOK = 8'hAA;
    localparam logic [7:0] RSP_BATNG = 8'hFC;

    localparam logic [1:0] EC_TMO   = 2'b01;
    localparam logic [1:0] EC_RETRY = 2'b10;
    localparam logic [1:0] EC_BAT   = 2'b11;

    state_t      state_q;
    logic [7:0]  tx_data_q;
    logic        tx_en_q;
    logic [7:0]  scode_q;
    logic        scode_en_q;
    logic        busy_q;
    logic        init_done_q;
    logic        err_q;
    logic [1:0]  err_code_q;
    logic [2:0]  led_q;
    logic [1:0]  retry_q;
    logic [31:0] tmo_q;
    logic        seq_init_q;   // 1: reset sequence, 0: LED sequence
    logic        led_byte2_q;  // LED sequence is sending the mask byte

    logic        init_go;
    logic        rx_ack;
    logic        rx_nak;
    logic        tmo_hit;
    logic [31:0] tmo_inc;

`ifdef KBD_CMD_SEQ_AUTO_INIT_EN
    logic auto_init_q;

    // One-cycle pseudo init request right after reset releases
    always_ff @(posedge clk) begin
        if (rst) auto_init_q <= 1'b1;
        else     auto_init_q <= 1'b0;
    end

    assign init_go = init_req | auto_init_q;
`else
    assign init_go = init_req;
`endif

    // Response decode and saturating timeout arithmetic
    always_comb begin
        rx_ack  = rx_en && (rx_scode == RSP_ACK);
        rx_nak  = (rx_en && (rx_scode == RSP_RSND)) || rx_err;
        tmo_hit = (tmo_q >= (TMO_CYC - 32'd1));
        tmo_inc = (tmo_q == '1) ? tmo_q : tmo_q + 32'd1;
    end

    // Sequencer FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            tx_data_q   <= '0;
            tx_en_q     <= 1'b0;
            scode_q     <= '0;
            scode_en_q  <= 1'b0;
            busy_q      <= 1'b0;
            init_done_q <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= '0;
            led_q       <= '0;
            retry_q     <= '0;
            tmo_q       <= '0;
            seq_init_q  <= 1'b0;
            led_byte2_q <= 1'b0;
        end else begin
            tx_en_q    <= 1'b0;
            scode_en_q <= 1'b0;
            case (state_q)
                IDLE, ERR: begin
                    if (rx_en) begin
                        scode_q    <= rx_scode;
                        scode_en_q <= 1'b1;
                    end
                    if (init_go || led_req) begin
                        err_q       <= 1'b0;
                        err_code_q  <= '0;
                        led_q       <= led_val;
                        retry_q     <= '0;
                        led_byte2_q <= 1'b0;
                        tx_en_q     <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= TX;
                        if (init_go) begin
                            seq_init_q  <= 1'b1;
                            init_done_q <= 1'b0;
                            tx_data_q   <= CMD_RESET;
                        end else begin
                            seq_init_q <= 1'b0;
                            tx_data_q  <= CMD_LED;
                        end
                    end
                end

                TX: begin
                    state_q <= WAIT_TXD;
                    tmo_q   <= '0;
                end

                WAIT_TXD: begin
                    if (tx_done) begin
                        state_q <= WAIT_ACK;
                        tmo_q   <= '0;
                    end else if (tmo_hit) begin
                        err_q      <= 1'b1;
                        err_code_q <= EC_TMO;
                        busy_q     <= 1'b0;
                        state_q    <= ERR;
                    end else begin
                        tmo_q <= tmo_inc;
                    end
                end

                // Any receive event outranks a simultaneous timeout expiry
                WAIT_ACK: begin
                    if (rx_ack) begin
                        retry_q <= '0;
                        if (seq_init_q) begin
                            state_q <= WAIT_BAT;
                            tmo_q   <= '0;
                        end else if (!led_byte2_q) begin
                            led_byte2_q <= 1'b1;
                            tx_data_q   <= {5'b0, led_q};
                            tx_en_q     <= 1'b1;
                            state_q     <= TX;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end else if (rx_nak) begin
                        if (retry_q < RETRY_MAX) begin
                            retry_q <= retry_q + 2'd1;
                            tx_en_q <= 1'b1;
                            state_q <= TX;
                        end else begin
                            err_q      <= 1'b1;
                            err_code_q <= EC_RETRY;
                            busy_q     <= 1'b0;
                            state_q    <= ERR;
                        end
                    end else if (!rx_en && tmo_hit) begin
                        err_q      <= 1'b1;
                        err_code_q <= EC_TMO;
                        busy_q     <= 1'b0;
                        state_q    <= ERR;
                    end else begin
                        tmo_q <= tmo_inc;
                    end
                end

                WAIT_BAT: begin
                    if (rx_en && (rx_scode == RSP_BATOK)) begin
                        init_done_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end else if (rx_en && (rx_scode == RSP_BATNG)) begin
                        err_q      <= 1'b1;
                        err_code_q <= EC_BAT;
                        busy_q     <= 1'b0;
                        state_q    <= ERR;
                    end else if (!rx_en && tmo_hit) begin
                        err_q      <= 1'b1;
                        err_code_q <= EC_TMO;
                        busy_q     <= 1'b0;
                        state_q    <= ERR;
                    end else begin
                        tmo_q <= tmo_inc;
                    end
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign tx_data      = tx_data_q;
    assign tx_en        = tx_en_q;
    assign scode_out    = scode_q;
    assign scode_out_en = scode_en_q;
    assign busy         = busy_q;
    assign init_done    = init_done_q;
    assign err          = err_q;
    assign err_code     = err_code_q;

endmodule

// File: doc/kbd_cmd_seq.md
KBD_CMD_SEQ -- requirements
Module: kbd_cmd_seq

Interface
REQ-001 SHALL have parameter TMO_CYC, default 32'd25_000_000, giving the per-wait timeout in clk cycles (500 ms at 50 MHz).
REQ-002 SHALL have parameter RETRY_MAX, default 2'd3, giving the maximum number of retransmissions per byte.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port init_req, input, 1 bit: one-cycle pulse requesting a keyboard reset sequence.
REQ-006 SHALL have port led_req, input, 1 bit: one-cycle pulse requesting an LED update.
REQ-007 SHALL have port led_val, input, 3 bits: {caps, num, scroll}.
REQ-008 SHALL have port tx_data, output, 8 bits: byte to the PS/2 transmitter.
REQ-009 SHALL have port tx_en, output, 1 bit: one-cycle transmit strobe.
REQ-010 SHALL have port tx_done, input, 1 bit: transmitter finished the byte.
REQ-011 SHALL have port rx_scode, input, 8 bits: received byte.
REQ-012 SHALL have port rx_en, input, 1 bit: rx_scode valid strobe.
REQ-013 SHALL have port rx_err, input, 1 bit: receive parity/framing error strobe.
REQ-014 SHALL have port scode_out, output, 8 bits: forwarded scancode.
REQ-015 SHALL have port scode_out_en, output, 1 bit: scode_out valid strobe.
REQ-016 SHALL have ports busy, init_done and err, outputs, 1 bit each: status.
REQ-017 SHALL have port err_code, output, 2 bits: 01 timeout, 10 retries exhausted, 11 BAT fail.

Function
REQ-018 SHALL implement states IDLE, TX, WAIT_TXD, WAIT_ACK, WAIT_BAT and ERR.
- busy = 1 in TX, WAIT_TXD, WAIT_ACK and WAIT_BAT.
REQ-019 SHALL accept init_req or led_req only in IDLE or ERR; requests in any other state are dropped.
- If both arrive in the same cycle, init wins and led_req is dropped.
REQ-020 On acceptance SHALL clear err and err_code, capture led_val, and reset the retry counter.
- init acceptance also clears init_done.
REQ-021 The init sequence SHALL be:
- send 0xFF, then WAIT_ACK;
- on 0xFA, go to WAIT_BAT;
- on 0xAA, set init_done and return to IDLE;
- on 0xFC, go to ERR with code 11.
REQ-022 The LED sequence SHALL be:
- send 0xED, then WAIT_ACK;
- on 0xFA, send {5'b0, led_val}, then WAIT_ACK;
- on 0xFA, return to IDLE.
REQ-023 TX SHALL drive tx_data and pulse tx_en for exactly one cycle, then enter WAIT_TXD; tx_done moves WAIT_TXD to the next wait state.
REQ-024 tx_en SHALL be asserted on the cycle after request acceptance (latency 1).
REQ-025 In WAIT_ACK, 0xFE or rx_err SHALL retransmit the current byte if retries < RETRY_MAX, incrementing the retry counter.
- Otherwise go to ERR with code 10.
- Any other rx byte is discarded.
REQ-026 The retry counter SHALL reset to 0 after each 0xFA.
REQ-027 A 32-bit timeout counter SHALL clear on entry to WAIT_TXD, WAIT_ACK or WAIT_BAT.
- Reaching TMO_CYC-1 enters ERR with code 01.
- The counter saturates; it never wraps.
REQ-028 In IDLE or ERR, each rx_en SHALL produce scode_out = rx_scode with a one-cycle scode_out_en pulse on the next cycle.
REQ-029 While busy, received bytes SHALL be consumed and not forwarded.
REQ-030 If rx_en and a timeout expiry occur in the same cycle, the received byte SHALL take priority.
REQ-031 ERR SHALL hold err = 1 and err_code until the next accepted request.

Reset
REQ-032 With rst = 1 at a clk edge, the block SHALL enter IDLE, abandoning any sequence in progress.
REQ-033 Reset values SHALL be:
- tx_en = 0, tx_data = 0x00, scode_out = 0x00, scode_out_en = 0;
- busy = 0, init_done = 0, err = 0, err_code = 00;
- counters = 0.

Configuration
REQ-034 With macro KBD_CMD_SEQ_AUTO_INIT_EN defined, the block SHALL start the init sequence automatically on the first cycle after rst deasserts, as if init_req had pulsed.
REQ-035 Without KBD_CMD_SEQ_AUTO_INIT_EN, the block SHALL wait in IDLE for init_req.

Verification
REQ-036 The bench SHALL cover these directed scenarios:
- init_req; tx_done; rx 0xFA; rx 0xAA -> tx_data = 0xFF with one tx_en, then init_done = 1, busy = 0, err = 0.
- led_req with led_val = 3'b101; ACK both bytes -> tx bytes 0xED then 0x05, then IDLE.
- init_req; rx 0xFE four times -> 0xFF sent 4 times total, then err = 1, err_code = 10.
- Small TMO_CYC (e.g. 100); init_req; tx_done, no response -> ERR with err_code = 01 exactly 100 cycles after tx_done.
- rx 0x1C in IDLE -> scode_out = 0x1C with one-cycle scode_out_en; rx 0x1C while in WAIT_BAT -> no scode_out_en.
- rst pulsed in WAIT_ACK -> next cycle IDLE with all outputs at reset values; init_req and led_req in the same cycle -> only 0xFF sent.
